// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and the memory stage.
// Data wins by default; fetch is forced in after two consecutive data grants under contention.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_valid,
  input  logic [5:0]        d_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        starve_q, starve_d;
  logic [7:0]        wait_q, wait_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_done_q, d_done_d;
  logic              if_done_q, if_done_d;
  logic              err_q, err_d;

  logic              d_req_s;
  logic              d_store_s;
  logic [1:0]        d_size_s;

  // opcode decode: which ops touch memory, direction and access size
  always_comb begin
    d_req_s   = 1'b0;
    d_store_s = 1'b0;
    d_size_s  = 2'd2;
    case (d_op)
      6'd32: begin d_req_s = d_valid; d_size_s = 2'd0; end
      6'd33: begin d_req_s = d_valid; d_size_s = 2'd1; end
      6'd34, 6'd35: begin d_req_s = d_valid; d_size_s = 2'd2; end
      6'd40: begin d_req_s = d_valid; d_store_s = 1'b1; d_size_s = 2'd0; end
      6'd41: begin d_req_s = d_valid; d_store_s = 1'b1; d_size_s = 2'd1; end
      6'd42: begin d_req_s = d_valid; d_store_s = 1'b1; d_size_s = 2'd2; end
      default: begin d_req_s = 1'b0; end
    endcase
  end

  // arbitration FSM next state, port registers and completion pulses
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    d_rdata_d   = d_rdata_q;
    if_rdata_d  = if_rdata_q;
    d_done_d    = 1'b0;
    if_done_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wait_d = 8'd0;
        // starve_q == 2 means the last two grants were data
        if (d_req_s && !(if_req && (starve_q == 2'd2))) begin
          state_d     = ST_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = d_store_s;
          mem_size_d  = d_size_s;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          starve_d    = (starve_q == 2'd2) ? 2'd2 : starve_q + 2'd1;
        end else if (if_req) begin
          state_d     = ST_FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_size_d  = 2'd2;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA, ST_FETCH: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          if (state_q == ST_DATA) begin
            d_done_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      starve_q    <= 2'd0;
      wait_q      <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      d_rdata_q   <= '0;
      if_rdata_q  <= '0;
      d_done_q    <= 1'b0;
      if_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rdata_q  <= if_rdata_d;
      d_done_q    <= d_done_d;
      if_done_q   <= if_done_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign if_done   = if_done_q;
  assign err       = err_q;

  // pipeline holds are combinational so a stage releases in its done cycle
  assign stall_mem = d_req_s & ~d_done_q;
  assign stall_if  = (if_req & ~if_done_q) | stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic if_done;
  logic d_valid = 1'b0;
  logic [5:0] d_op = 6'd0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic d_done, stall_if, stall_mem, mem_req, mem_we, err;
  logic [1:0] mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_ack = 1'b0;

  int tests = 0;
  int failed = 0;

  // model: 0 idle, 1 data, 2 fetch; hist holds the last two grants (1 = data)
  int m_state = 0;
  bit hist[$];
  bit m_store = 1'b0;
  int m_wait = 0;
  logic e_mem_req, e_we, e_d_done, e_if_done, e_err;
  logic [1:0] e_size;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_d_rdata, e_if_rdata;
  int ack_lat = 0;
  int req_cycles = 0;
  bit rand_lat = 1'b0;
  bit fixed_rd = 1'b0;
  logic [5:0] op_tbl [10] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd40, 6'd41, 6'd42, 6'd0, 6'd17, 6'd36};

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .d_valid(d_valid), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic bit mem_op(input logic v, input logic [5:0] op);
    return v && (op inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd40, 6'd41, 6'd42});
  endfunction

  task automatic model_reset();
    m_state = 0; hist.delete(); m_store = 1'b0; m_wait = 0; req_cycles = 0;
    e_mem_req = 1'b0; e_we = 1'b0; e_d_done = 1'b0; e_if_done = 1'b0; e_err = 1'b0;
    e_size = 2'd0; e_addr = '0; e_wdata = '0; e_d_rdata = '0; e_if_rdata = '0;
  endtask

  // predict what the design holds after the coming rising edge
  task automatic model_step();
    bit dq;
    bit st;
    int gnt;
    dq = mem_op(d_valid, d_op);
    st = d_op inside {6'd40, 6'd41, 6'd42};
    e_d_done = 1'b0; e_if_done = 1'b0; e_err = 1'b0;
    if (m_state == 0) begin
      gnt = 0;
      if (dq && if_req && hist.size() == 2 && hist[0] && hist[1]) gnt = 2;
      else if (dq) gnt = 1;
      else if (if_req) gnt = 2;
      if (gnt != 0) begin
        hist.push_back(gnt == 1);
        if (hist.size() > 2) hist.pop_front();
        m_state = gnt; m_wait = 0; e_mem_req = 1'b1; req_cycles = 0;
        if (gnt == 1) begin
          m_store = st; e_we = st; e_addr = d_addr; e_wdata = d_wdata;
          e_size = (d_op == 6'd32 || d_op == 6'd40) ? 2'd0 : (d_op == 6'd33 || d_op == 6'd41) ? 2'd1 : 2'd2;
        end else begin
          e_we = 1'b0; e_size = 2'd2; e_addr = if_addr;
        end
        if (rand_lat) ack_lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      end
    end else if (mem_ack) begin
      if (m_state == 1) begin
        e_d_done = 1'b1;
        if (!m_store) e_d_rdata = mem_rdata;
      end else begin
        e_if_done = 1'b1;
        e_if_rdata = mem_rdata;
      end
      m_state = 0; e_mem_req = 1'b0;
    end else if (m_wait + 1 == TO) begin
      e_err = 1'b1; m_state = 0; e_mem_req = 1'b0;
    end else begin
      m_wait++;
    end
  endtask

  // memory responder plus one model step and one clock cycle; ends on a falling edge
  task automatic tick();
    if (e_mem_req) mem_ack = (ack_lat >= 0) && (req_cycles >= ack_lat);
    else mem_ack = rand_lat && ($urandom_range(0, 3) == 0);
    mem_rdata = fixed_rd ? 32'hDEADBEEF : $urandom;
    if (e_mem_req) req_cycles++;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    d_valid = 1'b0; if_req = 1'b0; rand_lat = 1'b0; ack_lat = 0;
    for (int i = 0; i < 40 && (m_state != 0 || e_mem_req); i++) tick();
    tick();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({mem_req, mem_we, d_done, if_done, err} !== 5'b0) begin
      failed++; $display("FAIL reset_ctrl got=%b want=00000", {mem_req, mem_we, d_done, if_done, err});
    end
    tests++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_size !== 2'd0) begin
      failed++; $display("FAIL reset_port got addr=%h wdata=%h size=%0d want 0", mem_addr, mem_wdata, mem_size);
    end
    tests++;
    if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
      failed++; $display("FAIL reset_rdata got d=%h if=%h want 0", d_rdata, if_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    bit seen = 1'b0;
    d_valid = 1'b1; d_op = 6'd35; d_addr = 32'h100; d_wdata = $urandom;
    fixed_rd = 1'b1; ack_lat = 1; rand_lat = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (e_mem_req) begin
        tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_size !== 2'd2 || mem_addr !== 32'h100) begin
          failed++; $display("FAIL load_port got req=%b we=%b size=%0d addr=%h want 1 0 2 00000100", mem_req, mem_we, mem_size, mem_addr);
        end
      end
      if (e_d_done) seen = 1'b1;
    end
    tests++;
    if (!seen) begin failed++; $display("FAIL load_wait got no completion want done"); end
    tests++;
    if (d_done !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      failed++; $display("FAIL load_data got done=%b rdata=%h want 1 deadbeef", d_done, d_rdata);
    end
    tests++;
    if (stall_mem !== 1'b0) begin failed++; $display("FAIL load_stall got=%b want=0", stall_mem); end
    d_valid = 1'b0; fixed_rd = 1'b0;
    tick();
    tests++;
    if (d_done !== 1'b0 || mem_req !== 1'b0) begin
      failed++; $display("FAIL load_pulse got done=%b req=%b want 0 0", d_done, mem_req);
    end
  endtask

  task automatic test_store();
    bit seen = 1'b0;
    d_valid = 1'b1; d_op = 6'd40; d_addr = $urandom; d_wdata = 32'h000000AA; ack_lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (e_mem_req) begin
        tests++;
        if (mem_we !== 1'b1 || mem_size !== 2'd0 || mem_wdata !== 32'hAA) begin
          failed++; $display("FAIL store_port got we=%b size=%0d wdata=%h want 1 0 000000aa", mem_we, mem_size, mem_wdata);
        end
      end
      if (e_d_done) seen = 1'b1;
    end
    tests++;
    if (!seen || d_done !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      failed++; $display("FAIL store_done got done=%b rdata=%h want 1 deadbeef", d_done, d_rdata);
    end
    drain();
  endtask

  task automatic test_contention();
    logic [5:0] got = 6'd0;
    int n = 0;
    logic prev = 1'b0;
    pulse_reset();
    d_valid = 1'b1; d_op = 6'd34; d_addr = 32'h2000; if_req = 1'b1; if_addr = 32'h3000; ack_lat = 0;
    for (int i = 0; i < 80 && n < 6; i++) begin
      tick();
      if (mem_req === 1'b1 && prev !== 1'b1) begin
        got = {got[4:0], mem_addr == 32'h2000};
        n++;
      end
      prev = mem_req;
    end
    tests++;
    if (n != 6 || got !== 6'b110110) begin
      failed++; $display("FAIL contention_order got=%b (%0d grants) want=110110", got, n);
    end
    drain();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    d_valid = 1'b1; d_op = 6'd34; d_addr = $urandom; if_req = 1'b0; ack_lat = -1;
    for (int i = 0; i < 5 && mem_req !== 1'b1; i++) tick();
    if (mem_req === 1'b1) cnt = 1;
    while (mem_req === 1'b1 && cnt < 40) begin
      tick();
      if (mem_req === 1'b1) cnt++;
    end
    tests++;
    if (cnt != TO) begin failed++; $display("FAIL timeout_len got=%0d want=%0d", cnt, TO); end
    tests++;
    if (err !== 1'b1 || d_done !== 1'b0 || mem_req !== 1'b0) begin
      failed++; $display("FAIL timeout_err got err=%b done=%b req=%b want 1 0 0", err, d_done, mem_req);
    end
    ack_lat = 0;
    tick();
    tests++;
    if (mem_req !== 1'b1 || err !== 1'b0) begin
      failed++; $display("FAIL timeout_retry got req=%b err=%b want 1 0", mem_req, err);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    d_valid = 1'b1; d_op = 6'd33; d_addr = $urandom; ack_lat = -1;
    for (int i = 0; i < 4; i++) tick();
    #2 rst_n = 1'b0;
    model_reset();
    d_valid = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0) begin failed++; $display("FAIL rstmid_req got=%b want=0", mem_req); end
    @(negedge clk);
    rst_n = 1'b1; ack_lat = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (d_done !== 1'b0 || mem_req !== 1'b0) dones++;
    end
    tests++;
    if (dones != 0) begin failed++; $display("FAIL rstmid_after got=%0d active cycles want=0", dones); end
  endtask

  task automatic test_nonmem();
    bit seen = 1'b0;
    d_valid = 1'b1; d_op = 6'd0; if_req = 1'b1; if_addr = $urandom; ack_lat = 2;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      tests++;
      if (stall_mem !== 1'b0) begin failed++; $display("FAIL nonmem_stall got=%b want=0", stall_mem); end
      if (e_mem_req) begin
        tests++;
        if (mem_we !== 1'b0 || mem_size !== 2'd2 || mem_addr !== if_addr) begin
          failed++; $display("FAIL nonmem_port got we=%b size=%0d addr=%h want 0 2 %h", mem_we, mem_size, mem_addr, if_addr);
        end
      end
      if (e_if_done) seen = 1'b1;
    end
    tests++;
    if (!seen || if_done !== 1'b1 || if_rdata !== e_if_rdata) begin
      failed++; $display("FAIL nonmem_fetch got done=%b rdata=%h want 1 %h", if_done, if_rdata, e_if_rdata);
    end
    drain();
  endtask

  task automatic test_random();
    logic [5:0] got_ctl, exp_ctl;
    rand_lat = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      d_valid = 1'($urandom_range(0, 1));
      d_op = op_tbl[$urandom_range(0, 9)];
      if_req = 1'($urandom_range(0, 1));
      d_addr = $urandom; d_wdata = $urandom; if_addr = $urandom;
      tick();
      got_ctl = {mem_req, d_done, if_done, err, stall_mem, stall_if};
      exp_ctl = {e_mem_req, e_d_done, e_if_done, e_err, mem_op(d_valid, d_op) && !e_d_done,
                 (if_req && !e_if_done) || (mem_op(d_valid, d_op) && !e_d_done)};
      tests++;
      if (got_ctl !== exp_ctl) begin
        failed++; $display("FAIL rand_ctl cyc=%0d got=%b want=%b", i, got_ctl, exp_ctl);
      end
      tests++;
      if (d_rdata !== e_d_rdata || if_rdata !== e_if_rdata) begin
        failed++; $display("FAIL rand_rdata cyc=%0d got %h/%h want %h/%h", i, d_rdata, if_rdata, e_d_rdata, e_if_rdata);
      end
      if (e_mem_req) begin
        tests++;
        if (mem_we !== e_we || mem_size !== e_size || mem_addr !== e_addr ||
            (m_state == 1 && mem_wdata !== e_wdata)) begin
          failed++; $display("FAIL rand_port cyc=%0d got we=%b size=%0d addr=%h wdata=%h want %b %0d %h %h",
                             i, mem_we, mem_size, mem_addr, mem_wdata, e_we, e_size, e_addr, e_wdata);
        end
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_nonmem();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
